dlf_operand_tx: RTL and testbench



---
 rtl/dlf_operand_tx_if.sv | 20 ++
 rtl/dlf_operand_tx.sv | 85 ++++++++
 tb/tb_dlf_operand_tx.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlf_operand_tx_if.sv
// Source handshake and serial A/B beat bus of the DLFloat16 operand transmitter.
interface dlf_operand_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] data_out;
  logic        phase;
  logic        pair_sent;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, data_out, phase, pair_sent
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, data_out, phase, pair_sent
  );
endinterface

// File: rtl/dlf_operand_tx.sv
// Queues DLFloat16 operand pairs and serialises them as phase-locked A/B beats;
// slots with nothing queued carry a 0x0 pair, the MAC's neutral operation.
module dlf_operand_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dlf_operand_tx_if.slave        bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       sent_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      cur_b;
  logic [31:0]      head;
  logic             push;
  logic             pop;

  // No ready-through: a full FIFO refuses even on a pop edge.
  assign bus.in_ready = (level != FULL_LVL);
  assign push         = bus.in_valid && bus.in_ready && !flush;
  // Pops only look at the registered level, so a same-edge push never bypasses.
  assign pop          = bus.phase && (level != '0) && !flush;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Phase 0 edge emits the held B half; phase 1 edge starts the next pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.phase     <= 1'b0;
      bus.data_out  <= '0;
      bus.pair_sent <= 1'b0;
      cur_b         <= '0;
      sent_count    <= '0;
    end else if (!bus.phase) begin
      bus.phase     <= 1'b1;
      bus.data_out  <= cur_b;
      bus.pair_sent <= 1'b0;
    end else begin
      bus.phase <= 1'b0;
      if (pop) begin
        bus.data_out  <= head[31:16];
        cur_b         <= head[15:0];
        bus.pair_sent <= 1'b1;
        sent_count    <= sent_count + CNT_W'(1);
      end else begin
        bus.data_out  <= '0;
        cur_b         <= '0;
        bus.pair_sent <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dlf_operand_tx.sv
// Bench for dlf_operand_tx: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_dlf_operand_tx;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int SW    = 1 + 1 + 16 + LVL_W + CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] sent_count;
  int               checks = 0;
  int               errors = 0;

  dlf_operand_tx_if bus_if ();

  dlf_operand_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .flush     (flush),
    .level     (level),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  // Reference: a queue of pairs; every second edge starts a pair (or a zero pair).
  logic [31:0]      q[$];
  logic             m_phase;
  logic             m_ps;
  logic [15:0]      m_data;
  logic [15:0]      m_cur_b;
  logic [CNT_W-1:0] m_cnt;
  int               m_pushes = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] hd;
    bit          take;
    bit          give;
    if (!rst_n) begin
      q.delete();
      m_phase = 1'b0;
      m_ps    = 1'b0;
      m_data  = '0;
      m_cur_b = '0;
      m_cnt   = '0;
    end else begin
      take = m_phase && (q.size() != 0) && !flush;
      give = bus_if.in_valid && (q.size() < DEPTH) && !flush;
      if (flush) q.delete();
      if (!m_phase) begin
        m_data = m_cur_b;
        m_ps   = 1'b0;
      end else if (take) begin
        hd      = q.pop_front();
        m_data  = hd[31:16];
        m_cur_b = hd[15:0];
        m_ps    = 1'b1;
        m_cnt   = m_cnt + 1'b1;
      end else begin
        m_data  = '0;
        m_cur_b = '0;
        m_ps    = 1'b0;
      end
      if (give) begin
        q.push_back({bus_if.in_a, bus_if.in_b});
        m_pushes++;
      end
      m_phase = !m_phase;
    end
  end

  function automatic logic [SW-1:0] dut_vec();
    return {bus_if.phase, bus_if.pair_sent, bus_if.data_out, level, sent_count, bus_if.in_ready};
  endfunction

  function automatic logic [SW-1:0] model_vec();
    return {m_phase, m_ps, m_data, LVL_W'(q.size()), m_cnt, q.size() != DEPTH};
  endfunction

  task automatic align_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.phase === 1'b0 && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic ep;
    rst_n = 1'b0;
    flush = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_a = '0;
    bus_if.in_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== {1'b0, 1'b0, 16'h0, LVL_W'(0), CNT_W'(0), 1'b1}) begin
      errors++; $display("FAIL reset_vals got=%h exp=%h", dut_vec(), {1'b0, 1'b0, 16'h0, LVL_W'(0), CNT_W'(0), 1'b1});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.phase !== 1'b0) begin
      errors++; $display("FAIL reset_first_phase got=%b exp=0", bus_if.phase);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ep = (i % 2 == 0);
      checks++;
      if ({bus_if.phase, bus_if.pair_sent, bus_if.data_out, sent_count} !== {ep, 1'b0, 16'h0, CNT_W'(0)}) begin
        errors++; $display("FAIL reset_idle got=%b/%b/%h/%0d exp=%b/0/0000/0", bus_if.phase, bus_if.pair_sent, bus_if.data_out, sent_count, ep);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    align_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_align got=timeout exp=idle"); end
    bus_if.in_a = 16'h3E00;
    bus_if.in_b = 16'h4000;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    checks++;
    if (level !== LVL_W'(1) || bus_if.phase !== 1'b1) begin
      errors++; $display("FAIL single_queued got=lvl%0d/ph%b exp=lvl1/ph1", level, bus_if.phase);
    end
    @(negedge clk);
    checks++;
    if ({bus_if.phase, bus_if.pair_sent, bus_if.data_out} !== {1'b0, 1'b1, 16'h3E00}) begin
      errors++; $display("FAIL single_a got=%b/%b/%h exp=0/1/3e00", bus_if.phase, bus_if.pair_sent, bus_if.data_out);
    end
    checks++;
    if (sent_count !== CNT_W'(1)) begin
      errors++; $display("FAIL single_count got=%0d exp=1", sent_count);
    end
    @(negedge clk);
    checks++;
    if ({bus_if.phase, bus_if.pair_sent, bus_if.data_out} !== {1'b1, 1'b0, 16'h4000}) begin
      errors++; $display("FAIL single_b got=%b/%b/%h exp=1/0/4000", bus_if.phase, bus_if.pair_sent, bus_if.data_out);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL single_model got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_fill();
    bit               ok;
    bit               saw_full = 1'b0;
    bit               pend_pop = 1'b0;
    bit               want_b = 1'b0;
    int               start;
    int               n;
    logic [CNT_W-1:0] cnt0;
    logic [15:0]      pa[8];
    logic [15:0]      pb[8];
    logic [15:0]      ra[$];
    logic [15:0]      rb[$];
    for (int i = 0; i < 8; i++) begin
      pa[i] = {4'(i), 12'($urandom)};
      pb[i] = {4'(i + 8), 12'($urandom)};
    end
    align_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_align got=timeout exp=idle"); end
    cnt0  = m_cnt;
    start = m_pushes;
    bus_if.in_a = pa[0];
    bus_if.in_b = pb[0];
    bus_if.in_valid = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL fill_cycle got=%h exp=%h", dut_vec(), model_vec());
      end
      if (pend_pop) begin
        checks++;
        if (level !== LVL_W'(DEPTH - 1)) begin
          errors++; $display("FAIL fill_pop_from_full got=lvl%0d exp=lvl%0d", level, DEPTH - 1);
        end
        pend_pop = 1'b0;
      end
      if (level == LVL_W'(DEPTH)) saw_full = 1'b1;
      if (bus_if.pair_sent) begin
        ra.push_back(bus_if.data_out);
        want_b = 1'b1;
      end else if (want_b) begin
        rb.push_back(bus_if.data_out);
        want_b = 1'b0;
      end
      n = m_pushes - start;
      if (n >= 8) begin
        bus_if.in_valid = 1'b0;
      end else begin
        bus_if.in_a = pa[n];
        bus_if.in_b = pb[n];
      end
      if (level == LVL_W'(DEPTH) && bus_if.phase && bus_if.in_valid) begin
        pend_pop = 1'b1;
        checks++;
        if (bus_if.in_ready !== 1'b0) begin
          errors++; $display("FAIL fill_ready_full got=%b exp=0", bus_if.in_ready);
        end
      end
      if (rb.size() == 8) break;
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (rb.size() != 8) begin
      errors++; $display("FAIL fill_drain got=%0d exp=8 pairs", rb.size());
    end
    checks++;
    if (!saw_full) begin
      errors++; $display("FAIL fill_full got=no_full exp=level%0d", DEPTH);
    end
    for (int i = 0; i < rb.size(); i++) begin
      checks++;
      if (ra[i] !== pa[i] || rb[i] !== pb[i]) begin
        errors++; $display("FAIL fill_order[%0d] got=%h/%h exp=%h/%h", i, ra[i], rb[i], pa[i], pb[i]);
      end
    end
    checks++;
    if (sent_count !== cnt0 + CNT_W'(8) || level !== LVL_W'(0)) begin
      errors++; $display("FAIL fill_end got=cnt%0d/lvl%0d exp=cnt%0d/lvl0", sent_count, level, cnt0 + CNT_W'(8));
    end
  endtask

  task automatic test_flush();
    bit          ok;
    logic [15:0] a[4];
    logic [15:0] b[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'($urandom) | 16'h0001;
      b[i] = 16'($urandom) | 16'h0001;
    end
    // Flush on a phase-1 edge with a simultaneous push.
    align_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_align got=timeout exp=idle"); end
    for (int i = 0; i < 3; i++) begin
      bus_if.in_a = a[i];
      bus_if.in_b = b[i];
      bus_if.in_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bus_if.data_out !== b[0] || level !== LVL_W'(2) || bus_if.phase !== 1'b1) begin
      errors++; $display("FAIL flush_pre got=%h/lvl%0d/ph%b exp=%h/lvl2/ph1", bus_if.data_out, level, bus_if.phase, b[0]);
    end
    flush = 1'b1;
    bus_if.in_a = a[3];
    bus_if.in_b = b[3];
    @(negedge clk);
    flush = 1'b0;
    bus_if.in_valid = 1'b0;
    checks++;
    if ({bus_if.phase, bus_if.pair_sent, bus_if.data_out, level} !== {1'b0, 1'b0, 16'h0, LVL_W'(0)}) begin
      errors++; $display("FAIL flush_slot got=%b/%b/%h/lvl%0d exp=0/0/0000/lvl0", bus_if.phase, bus_if.pair_sent, bus_if.data_out, level);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.pair_sent !== 1'b0 || bus_if.data_out !== 16'h0 || level !== LVL_W'(0)) begin
        errors++; $display("FAIL flush_idle got=%b/%h/lvl%0d exp=0/0000/lvl0", bus_if.pair_sent, bus_if.data_out, level);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL flush_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    // Flush on a phase-0 edge: the pair on the bus still delivers its B half.
    align_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush2_align got=timeout exp=idle"); end
    bus_if.in_a = a[0];
    bus_if.in_b = b[0];
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_a = a[1];
    bus_if.in_b = b[1];
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    checks++;
    if (bus_if.data_out !== a[0] || bus_if.pair_sent !== 1'b1 || level !== LVL_W'(1)) begin
      errors++; $display("FAIL flush2_a got=%h/%b/lvl%0d exp=%h/1/lvl1", bus_if.data_out, bus_if.pair_sent, level, a[0]);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (bus_if.data_out !== b[0] || bus_if.phase !== 1'b1 || level !== LVL_W'(0)) begin
      errors++; $display("FAIL flush2_b got=%h/ph%b/lvl%0d exp=%h/ph1/lvl0", bus_if.data_out, bus_if.phase, level, b[0]);
    end
    @(negedge clk);
    checks++;
    if (bus_if.data_out !== 16'h0 || bus_if.pair_sent !== 1'b0) begin
      errors++; $display("FAIL flush2_after got=%h/%b exp=0000/0", bus_if.data_out, bus_if.pair_sent);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL flush2_model got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    logic ep;
    align_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_align got=timeout exp=idle"); end
    for (int i = 0; i < 3; i++) begin
      bus_if.in_a = 16'h1000 + 16'(i);
      bus_if.in_b = 16'h2000 + 16'(i);
      bus_if.in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (bus_if.phase !== 1'b1 || bus_if.data_out !== 16'h2000 || level !== LVL_W'(2)) begin
      errors++; $display("FAIL rstmid_pre got=ph%b/%h/lvl%0d exp=ph1/2000/lvl2", bus_if.phase, bus_if.data_out, level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {1'b0, 1'b0, 16'h0, LVL_W'(0), CNT_W'(0), 1'b1}) begin
      errors++; $display("FAIL rstmid_async got=%h exp=%h", dut_vec(), {1'b0, 1'b0, 16'h0, LVL_W'(0), CNT_W'(0), 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ep = (i % 2 == 0);
      checks++;
      if ({bus_if.phase, bus_if.pair_sent, bus_if.data_out, level} !== {ep, 1'b0, 16'h0, LVL_W'(0)}) begin
        errors++; $display("FAIL rstmid_idle got=%b/%b/%h/lvl%0d exp=%b/0/0000/lvl0", bus_if.phase, bus_if.pair_sent, bus_if.data_out, level, ep);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL rstmid_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_cycle[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
      end
      bus_if.in_valid = ($urandom_range(0, 9) < 7);
      bus_if.in_a = 16'($urandom);
      bus_if.in_b = 16'($urandom);
      flush = ($urandom_range(0, 19) == 0);
    end
    bus_if.in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_drain got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (level !== LVL_W'(0) || bus_if.pair_sent !== 1'b0) begin
      errors++; $display("FAIL random_end got=lvl%0d/%b exp=lvl0/0", level, bus_if.pair_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
